mips_store_monitor: RTL

//  Consumer end of the single-cycle MIPS store bus (memwrite/dataadr/writedata/pc from top).

---
 rtl/mips_mon_pkg.sv | 43 ++++
 rtl/mon_fifo.sv | 70 +++++++
 rtl/mips_store_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mon_pkg.sv
// Shared types for the MIPS store-bus monitor: FSM states, verdict codes,
// the expected-store payload and the masked store compare.
package mips_mon_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PASS = 2'b10,
    FAIL = 2'b11
  } mon_state_t;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_MISMATCH   = 2'b01,
    FC_UNEXPECTED = 2'b10,
    FC_TIMEOUT    = 2'b11
  } fail_code_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } store_t;

  // Address always compared in full; data byte i only where mask[i] is set.
  function automatic logic store_match(input store_t            exp,
                                       input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] data);
    logic ok;
    ok = (exp.addr == addr);
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (exp.mask[i] && (exp.data[8*i +: 8] != data[8*i +: 8])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/mon_fifo.sv
// Synchronous FIFO of expected stores; flush beats pop and push on the same edge.
module mon_fifo
  import mips_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  store_t                   din,
  output store_t                   head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  store_t          mem [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  assign full_c  = (cnt_q == CW'(DEPTH));
  assign empty_c = (cnt_q == '0);
  assign head_c  = mem[rd_q];
  assign count   = cnt_q;
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_q] <= din;
    end
  end

endmodule

// File: rtl/mips_store_monitor.sv
// Checks CPU stores against a queue of expected stores and reports a verdict.
// Define STORE_MON_MASK_EN to add a per-entry byte mask (exp_mask) on the data compare.
module mips_store_monitor
  import mips_mon_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      exp_valid,
  output logic                      exp_ready,
  input  logic [31:0]               exp_addr,
  input  logic [31:0]               exp_data,
`ifdef STORE_MON_MASK_EN
  input  logic [3:0]                exp_mask,
`endif
  input  logic                      start,
  input  logic                      memwrite,
  input  logic [31:0]               dataadr,
  input  logic [31:0]               writedata,
  input  logic [31:0]               pc,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [1:0]                fail_code,
  output logic [$clog2(DEPTH):0]    match_count,
  output logic [31:0]               fail_pc,
  output logic [31:0]               fail_addr,
  output logic [31:0]               fail_data
);

  localparam int unsigned MW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  mon_state_t    state_q, state_d;
  fail_code_t    fc_q, fc_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic [MW-1:0] mc_q, mc_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   fad_q, fad_d;
  logic [31:0]   fda_q, fda_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          exp_ready_q, exp_ready_d;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          full_c, empty_c;
  logic [MW-1:0] fifo_count;
  logic [MW-1:0] cnt_nxt;
  store_t        din, head_c;
  logic          hit, head_last, timeout_hit;

`ifdef STORE_MON_MASK_EN
  assign din = '{addr: exp_addr, data: exp_data, mask: exp_mask};
`else
  assign din = '{addr: exp_addr, data: exp_data, mask: {MASK_W{1'b1}}};
`endif

  mon_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .din     (din),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (fifo_count)
  );

  assign hit         = store_match(head_c, dataadr, writedata);
  assign head_last   = (fifo_count == MW'(1));
  assign timeout_hit = (cyc_q == TW'(TIMEOUT - 1));

  // Next-state, verdict and queue control; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    cyc_d      = cyc_q;
    mc_d       = mc_q;
    fpc_d      = fpc_q;
    fad_d      = fad_q;
    fda_d      = fda_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      fifo_flush = 1'b1;
      fc_d       = FC_NONE;
      cyc_d      = '0;
      mc_d       = '0;
      fpc_d      = '0;
      fad_d      = '0;
      fda_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          fifo_push = exp_valid && exp_ready_q;
          if (start) begin
            if (!empty_c) begin
              state_d = RUN;
              cyc_d   = '0;
            end else begin
              state_d = PASS;
            end
          end
        end
        RUN: begin
          cyc_d = cyc_q + TW'(1);
          if (memwrite && hit) begin
            fifo_pop = 1'b1;
            if (mc_q != MW'(DEPTH)) mc_d = mc_q + MW'(1);
          end
          // A final match outranks a timeout landing on the same edge.
          if (memwrite && !hit) begin
            state_d = FAIL;
            fc_d    = FC_MISMATCH;
            fpc_d   = pc;
            fad_d   = dataadr;
            fda_d   = writedata;
          end else if (memwrite && head_last) begin
            state_d = PASS;
          end else if (timeout_hit) begin
            state_d = FAIL;
            fc_d    = FC_TIMEOUT;
            fpc_d   = '0;
            fad_d   = '0;
            fda_d   = '0;
          end
        end
        PASS: begin
          if (memwrite) begin
            state_d = FAIL;
            fc_d    = FC_UNEXPECTED;
            fpc_d   = pc;
            fad_d   = dataadr;
            fda_d   = writedata;
          end
        end
        default: begin
        end
      endcase
    end

    cnt_nxt     = fifo_flush ? '0
                : fifo_count + MW'(fifo_push && !full_c) - MW'(fifo_pop && !empty_c);
    exp_ready_d = (state_d == IDLE) && (cnt_nxt != MW'(DEPTH));
    busy_d      = (state_d == RUN);
    done_d      = (state_d == PASS) || (state_d == FAIL);
    pass_d      = (state_d == PASS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fc_q        <= FC_NONE;
      cyc_q       <= '0;
      mc_q        <= '0;
      fpc_q       <= '0;
      fad_q       <= '0;
      fda_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exp_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      cyc_q       <= cyc_d;
      mc_q        <= mc_d;
      fpc_q       <= fpc_d;
      fad_q       <= fad_d;
      fda_q       <= fda_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      exp_ready_q <= exp_ready_d;
    end
  end

  assign exp_ready   = exp_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fc_q;
  assign match_count = mc_q;
  assign fail_pc     = fpc_q;
  assign fail_addr   = fad_q;
  assign fail_data   = fda_q;

endmodule
